div_cmd_sequencer: RTL

Upstream command stage for the 8-bit restoring divider. It buffers dividend/divisor pairs in a small FIFO and issues them one at a time over the divider's st/ready protocol. It captures quotient (Qbus_out) and remainder (Abus_out) and returns them on a valid/ready response channel. Divide-by-zero is intercepted without touching the divider, and a hung divider is covered by a timeout.

---
 rtl/div_seq_pkg.sv | 31 +++
 rtl/div_cmd_fifo.sv | 54 +++++
 rtl/div_cmd_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared types for the divider command sequencer: FSM states, command and response records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_seq_pkg;

    // Record width; the sequencer's WIDTH parameter must equal this.
    localparam int DIV_W = 8;

    localparam logic [DIV_W-1:0] DZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    typedef struct packed {
        logic [DIV_W-1:0] dividend;
        logic [DIV_W-1:0] divisor;
    } div_cmd_t;

    typedef struct packed {
        logic [DIV_W-1:0] quotient;
        logic [DIV_W-1:0] remainder;
        logic             dz;
        logic             timeout;
    } div_rsp_t;

endpackage

// File: rtl/div_cmd_fifo.sv
// Command FIFO holding dividend/divisor pairs ahead of the divider.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: full blocks pushes, pops on empty are ignored.
module div_cmd_fifo
    import div_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_vld,
    input  div_cmd_t push_dat,
    input  logic     pop_rdy,
    output div_cmd_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    div_cmd_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_en;
    logic          pop_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_en = push_vld && !full;
    assign pop_en  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_cmd_sequencer.sv
// Buffers divide commands and issues them one at a time to the restoring divider over st/ready.
// Latency: 1 (pop) + 1 (st) + divider latency + 1 to rsp_valid; divide-by-zero answers in 1 cycle.
// Backpressure: cmd_ready drops when the FIFO is full; a held response blocks the next issue.
module div_cmd_sequencer
    import div_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_dividend,
    input  logic [WIDTH-1:0] cmd_divisor,
    output logic             div_st,
    output logic [WIDTH-1:0] div_qbus,
    output logic [WIDTH-1:0] div_mbus,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_abus,
    input  logic [WIDTH-1:0] div_qres,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_dz,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    div_cmd_t       op_q;
    div_cmd_t       op_nxt;
    div_rsp_t       rsp_q;
    div_rsp_t       rsp_nxt;
    div_cmd_t       fifo_in;
    div_cmd_t       fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           rdy_en;

    assign fifo_in = '{dividend: cmd_dividend, divisor: cmd_divisor};

    div_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_valid && cmd_ready),
        .push_dat (fifo_in),
        .pop_rdy  (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        rsp_nxt   = rsp_q;
        fifo_pop  = 1'b0;
        unique case (state)
            IDLE: begin
                // rsp_valid is only high in RESP, so reaching IDLE means no response is pending.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_nxt   = fifo_head;
                    if (fifo_head.divisor == '0) begin
                        rsp_nxt   = '{quotient: DZ_QUOTIENT, remainder: fifo_head.dividend,
                                      dz: 1'b1, timeout: 1'b0};
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!div_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    rsp_nxt   = '{quotient: '0, remainder: '0, dz: 1'b0, timeout: 1'b1};
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (div_ready) begin
                    rsp_nxt   = '{quotient: div_qres, remainder: div_abus, dz: 1'b0, timeout: 1'b0};
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    rsp_nxt   = '{quotient: '0, remainder: '0, dz: 1'b0, timeout: 1'b1};
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            rsp_q  <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            rsp_q  <= rsp_nxt;
            rdy_en <= 1'b1;
        end
    end

    // Outputs decode registered state only, so reset clears them without waiting for a clock.
    assign cmd_ready     = rdy_en && !fifo_full;
    assign div_st        = (state == ISSUE);
    assign div_qbus      = op_q.dividend;
    assign div_mbus      = op_q.divisor;
    assign rsp_valid     = (state == RESP);
    assign rsp_quotient  = rsp_q.quotient;
    assign rsp_remainder = rsp_q.remainder;
    assign rsp_dz        = rsp_q.dz;
    assign rsp_timeout   = rsp_q.timeout;
    assign busy          = (state != IDLE) || !fifo_empty;

endmodule
